workload_predictor: RTL and testbench
=====================================

# workload_predictor

Upstream stage of the adaptive power controller. Watches task arrival and completion pulses and keeps a backlog count and a windowed, exponentially averaged arrival rate. A hysteresis state machine turns these into the registered `predict` signal that the power controller uses to gate its four worker clocks. Adds on/off hysteresis and a backlog override, so worker clocks do not toggle on short bursts.

## Interface
- `WINDOW`, 16: cycles per measurement window; 2..255.
- `CNT_W`, 8: width of the window arrival counter and `rate_avg`; WINDOW < 2^CNT_W.
- `EWMA_SHIFT`, 2: averaging weight 1/2^EWMA_SHIFT.
- `ON_THRESH`, 8: rate at or above which workers turn on.
- `OFF_THRESH`, 3: rate at or below which the hold-off starts; OFF_THRESH < ON_THRESH.
- `HOLD_WINDOWS`, 2: consecutive low windows spent in HOLD before OFF; at least 1.
- `BACKLOG_W`, 6: width of the backlog counter.
- `BACKLOG_HI`, 16: backlog at or above which ON is forced; less than 2^BACKLOG_W.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `task_arrive`  in  1: one task arrived this cycle.
- `task_done`  in  1: one task completed this cycle.
- `force_on`  in  1: synchronous override that forces ON.
- `predict`  out  1: registered; to the power controller's `predict` input.
- `rate_avg`  out  CNT_W: averaged arrivals per window.
- `backlog`  out  BACKLOG_W: outstanding tasks.
- `window_tick`  out  1: one-cycle pulse marking that `rate_avg` has just updated.
- `state_o`  out  2: FSM state, for debug.

## Operation
- Reset value of all registers and outputs: 0. The FSM resets to OFF.

Window counter:
- `win_cnt` counts 0..WINDOW-1 and wraps.
- A window-end cycle is a cycle where `win_cnt` == WINDOW-1.
- `arr_cnt` counts `task_arrive` pulses, including any arrival in the window-end cycle.
- On the window-end edge, `arr_cnt` clears to 0.

EWMA:
- Internal accumulator `acc` is CNT_W+EWMA_SHIFT bits wide.
- On the window-end edge: acc_next = acc - (acc >> EWMA_SHIFT) + sample.
- `sample` is the final `arr_cnt` value, including the arrival in the window-end cycle.
- `rate_avg` = acc >> EWMA_SHIFT. The FSM uses rate_next = acc_next >> EWMA_SHIFT.

Backlog:
- Arrive only: +1, saturating at 2^BACKLOG_W-1.
- Done only: -1; ignored when backlog is 0.
- Arrive and done together: unchanged.

FSM states: OFF=0, ON=1, HOLD=2. Transitions:
- Priority 1, every cycle: if `force_on` is high or registered `backlog` >= BACKLOG_HI, next state is ON. This applies from any state and reloads nothing.
- Otherwise, state changes only on window-end edges:
  - OFF: rate_next >= ON_THRESH → ON.
  - ON: rate_next <= OFF_THRESH → HOLD, with hold_cnt = HOLD_WINDOWS.
  - HOLD: rate_next > OFF_THRESH → ON.
  - HOLD, otherwise: hold_cnt == 1 → OFF; else decrement hold_cnt.
- `predict` is a registered copy of (next state is ON or HOLD).

## Timing
- `predict`, `state_o`, `rate_avg` and `acc` update on the same edge: the window-end edge, or the edge where an override is first seen.
- `window_tick` is high for the cycle after each window-end edge, coincident with the new `rate_avg`.
- Backlog override latency: 1 cycle from registered `backlog` reaching BACKLOG_HI. That is 2 edges after the arrival pulse that causes it.
- Windows never stall; `win_cnt` runs during overrides.
- `reset_n` low mid-operation: all outputs drop to 0 asynchronously.
- Release of `reset_n`: synchronised deassertion is handled at top level. The first window starts with `win_cnt` = 0.

## Structure
- Shared package `power_pkg` holds:
  - the state encodings OFF/ON/HOLD;
  - the default thresholds, shared with the power controller's active-count display logic.
- Sub-module `ewma_filter` holds the accumulator, shift and update strobe, parameterised by CNT_W and EWMA_SHIFT. It outputs `rate_avg` and `rate_next`.

## Test plan
All scenarios use default parameters.
- Reset: hold `reset_n` low for 3 cycles, then pulse activity inputs. All outputs stay 0; `window_tick` first rises at cycle 16 after release.
- Ramp-up: `task_arrive` = `task_done` = 1 every cycle.
  - `rate_avg` goes 4, 7, 9 at successive window ends.
  - `predict` rises at the third window-end edge (ON).
- Ramp-down: continue from the ramp-up, then stop all arrivals.
  - `rate_avg` goes 7, 5, 4, 3; HOLD is entered at the 4th window end.
  - `rate_avg` then goes 2 (still HOLD), then 1 (OFF).
  - `predict` falls at the 6th window end.
- Backlog override: from reset, 16 consecutive arrivals with no completions.
  - `backlog` reaches 16; `predict` goes to 1 one edge later, mid-window.
  - Then 16 completions: `predict` stays 1 until the window-rate rules allow HOLD and then OFF.
- Backlog edges:
  - Done with backlog 0: backlog stays 0.
  - Arrive and done together at 5: backlog stays 5.
  - 70 arrivals: backlog saturates at 63.
- Force and async reset:
  - `force_on` pulsed in OFF gives `predict` = 1 on the next edge.
  - `reset_n` asserted while ON drops `predict` to 0 with no clock edge.

Source files
------------

// File: rtl/power_pkg.sv
`default_nettype none
// ============================================================================
// Module      : power_pkg
// Description : Shared state encodings and default thresholds used by the
//               workload predictor and the power controller display logic.
// Revision    : 1.0 - initial release
// ============================================================================
package power_pkg;

    // Hysteresis FSM state encodings
    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_ON   = 2'd1,
        ST_HOLD = 2'd2
    } wp_state_t;

    // Default measurement and threshold settings
    localparam int DEF_WINDOW       = 16;
    localparam int DEF_CNT_W        = 8;
    localparam int DEF_EWMA_SHIFT   = 2;
    localparam int DEF_ON_THRESH    = 8;
    localparam int DEF_OFF_THRESH   = 3;
    localparam int DEF_HOLD_WINDOWS = 2;
    localparam int DEF_BACKLOG_W    = 6;
    localparam int DEF_BACKLOG_HI   = 16;

endpackage : power_pkg
`default_nettype wire

// File: rtl/workload_predictor_if.sv
`default_nettype none
// ============================================================================
// Module      : workload_predictor_if
// Description : Task activity inputs and prediction outputs of the workload
//               predictor. The slave side is the predictor itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface workload_predictor_if #(
    parameter int CNT_W     = 8,
    parameter int BACKLOG_W = 6
);
    logic                 task_arrive;
    logic                 task_done;
    logic                 force_on;
    logic                 predict;
    logic [CNT_W-1:0]     rate_avg;
    logic [BACKLOG_W-1:0] backlog;
    logic                 window_tick;
    logic [1:0]           state_o;

    // Activity source / prediction consumer
    modport master (
        output task_arrive, task_done, force_on,
        input  predict, rate_avg, backlog, window_tick, state_o
    );

    // Predictor
    modport slave (
        input  task_arrive, task_done, force_on,
        output predict, rate_avg, backlog, window_tick, state_o
    );
endinterface : workload_predictor_if
`default_nettype wire

// File: rtl/ewma_filter.sv
`default_nettype none
// ============================================================================
// Module      : ewma_filter
// Description : Exponentially weighted moving average of per-window samples.
//               acc' = acc - (acc >> SHIFT) + sample, rate = acc >> SHIFT.
//               Also emits a one-cycle strobe after each update.
// Revision    : 1.0 - initial release
// ============================================================================
module ewma_filter #(
    parameter int CNT_W      = 8,
    parameter int EWMA_SHIFT = 2
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    input  wire logic             update_i,
    input  wire logic [CNT_W-1:0] sample_i,
    output logic      [CNT_W-1:0] rate_avg_o,
    output logic      [CNT_W-1:0] rate_next_o,
    output logic                  tick_o
);
    localparam int ACC_W = CNT_W + EWMA_SHIFT;

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic             tick_q;

    // Candidate accumulator value; only committed on an update strobe
    always_comb begin
        acc_d = acc_q - (acc_q >> EWMA_SHIFT) + ACC_W'(sample_i);
    end

    // Accumulator and update strobe registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= update_i;
            if (update_i) begin
                acc_q <= acc_d;
            end
        end
    end

    assign rate_avg_o  = CNT_W'(acc_q >> EWMA_SHIFT);
    assign rate_next_o = CNT_W'(acc_d >> EWMA_SHIFT);
    assign tick_o      = tick_q;

endmodule : ewma_filter
`default_nettype wire

// File: rtl/workload_predictor.sv
`default_nettype none
// ============================================================================
// Module      : workload_predictor
// Description : Counts task arrivals per window, averages the rate, tracks the
//               backlog and drives a hysteresis FSM whose registered predict
//               output gates the power controller's worker clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module workload_predictor
    import power_pkg::*;
#(
    parameter int WINDOW       = DEF_WINDOW,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int EWMA_SHIFT   = DEF_EWMA_SHIFT,
    parameter int ON_THRESH    = DEF_ON_THRESH,
    parameter int OFF_THRESH   = DEF_OFF_THRESH,
    parameter int HOLD_WINDOWS = DEF_HOLD_WINDOWS,
    parameter int BACKLOG_W    = DEF_BACKLOG_W,
    parameter int BACKLOG_HI   = DEF_BACKLOG_HI
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    workload_predictor_if.slave   bus
);
    localparam int HOLD_W = (HOLD_WINDOWS < 2) ? 1 : $clog2(HOLD_WINDOWS + 1);

    localparam logic [CNT_W-1:0]     WIN_LAST  = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0]     ON_T      = CNT_W'(ON_THRESH);
    localparam logic [CNT_W-1:0]     OFF_T     = CNT_W'(OFF_THRESH);
    localparam logic [BACKLOG_W-1:0] BL_HI     = BACKLOG_W'(BACKLOG_HI);
    localparam logic [BACKLOG_W-1:0] BL_MAX    = {BACKLOG_W{1'b1}};
    localparam logic [HOLD_W-1:0]    HOLD_LOAD = HOLD_W'(HOLD_WINDOWS);
    localparam logic [HOLD_W-1:0]    HOLD_ONE  = HOLD_W'(1);

    logic [CNT_W-1:0]     win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0]     arr_cnt_q, arr_cnt_d;
    logic [BACKLOG_W-1:0] backlog_q, backlog_d;
    logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
    wp_state_t            state_q, state_d;
    logic                 predict_q;

    logic                 win_end;
    logic [CNT_W-1:0]     sample;
    logic [CNT_W-1:0]     rate_avg;
    logic [CNT_W-1:0]     rate_next;
    logic                 tick;
    logic                 override;

    assign win_end  = (win_cnt_q == WIN_LAST);
    // The arrival in the window-end cycle still belongs to the closing window
    assign sample   = arr_cnt_q + CNT_W'(bus.task_arrive);
    assign override = bus.force_on || (backlog_q >= BL_HI);

    // Window position and per-window arrival count
    always_comb begin
        win_cnt_d = win_end ? '0 : win_cnt_q + 1'b1;
        arr_cnt_d = win_end ? '0 : sample;
    end

    // Backlog: saturate up, ignore completions when empty
    always_comb begin
        backlog_d = backlog_q;
        case ({bus.task_arrive, bus.task_done})
            2'b10:   if (backlog_q != BL_MAX) backlog_d = backlog_q + 1'b1;
            2'b01:   if (backlog_q != '0)     backlog_d = backlog_q - 1'b1;
            default: backlog_d = backlog_q;
        endcase
    end

    // Counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_cnt_q <= '0;
            arr_cnt_q <= '0;
            backlog_q <= '0;
        end else begin
            win_cnt_q <= win_cnt_d;
            arr_cnt_q <= arr_cnt_d;
            backlog_q <= backlog_d;
        end
    end

    ewma_filter #(
        .CNT_W      (CNT_W),
        .EWMA_SHIFT (EWMA_SHIFT)
    ) u_ewma (
        .clk         (clk),
        .reset_n     (reset_n),
        .update_i    (win_end),
        .sample_i    (sample),
        .rate_avg_o  (rate_avg),
        .rate_next_o (rate_next),
        .tick_o      (tick)
    );

    // Hysteresis next-state: overrides act every cycle, rate rules only at window end
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        if (override) begin
            state_d = ST_ON;
        end else if (win_end) begin
            case (state_q)
                ST_OFF: begin
                    if (rate_next >= ON_T) state_d = ST_ON;
                end
                ST_ON: begin
                    if (rate_next <= OFF_T) begin
                        state_d    = ST_HOLD;
                        hold_cnt_d = HOLD_LOAD;
                    end
                end
                ST_HOLD: begin
                    if (rate_next > OFF_T) begin
                        state_d = ST_ON;
                    end else if (hold_cnt_q == HOLD_ONE) begin
                        state_d = ST_OFF;
                    end else begin
                        hold_cnt_d = hold_cnt_q - 1'b1;
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end
    end

    // FSM state, hold counter and registered predict output
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_OFF;
            hold_cnt_q <= '0;
            predict_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            predict_q  <= (state_d == ST_ON) || (state_d == ST_HOLD);
        end
    end

    assign bus.predict     = predict_q;
    assign bus.rate_avg    = rate_avg;
    assign bus.backlog     = backlog_q;
    assign bus.window_tick = tick;
    assign bus.state_o     = state_q;

endmodule : workload_predictor
`default_nettype wire

// File: tb/tb_workload_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_workload_predictor
// Description : Directed self-checking bench for workload_predictor with
//               default parameters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_workload_predictor;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    workload_predictor_if #(.CNT_W(8), .BACKLOG_W(6)) wp_if ();

    workload_predictor dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (wp_if)
    );

    // Advance one edge and settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic clear_inputs();
        wp_if.task_arrive = 1'b0;
        wp_if.task_done   = 1'b0;
        wp_if.force_on    = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_inputs();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear_inputs();
        repeat (3) @(posedge clk);
        #1;
        wp_if.task_arrive = 1'b1;
        wp_if.task_done   = 1'b1;
        wp_if.force_on    = 1'b1;
        step();
        checks++;
        if ({wp_if.predict, wp_if.rate_avg, wp_if.backlog, wp_if.window_tick, wp_if.state_o} !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs: got p=%0d r=%0d b=%0d t=%0d s=%0d required all 0",
                     wp_if.predict, wp_if.rate_avg, wp_if.backlog, wp_if.window_tick, wp_if.state_o);
        end
        clear_inputs();
        reset_n = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            step();
            checks++;
            if (wp_if.window_tick !== (i == 16)) begin
                errors++;
                $display("FAIL reset_tick cycle %0d: got %0d required %0d", i, wp_if.window_tick, (i == 16));
            end
        end
        checks++;
        if (wp_if.predict !== 1'b0 || wp_if.rate_avg !== 8'd0 || wp_if.state_o !== 2'd0) begin
            errors++;
            $display("FAIL reset_idle: got p=%0d r=%0d s=%0d required 0 0 0",
                     wp_if.predict, wp_if.rate_avg, wp_if.state_o);
        end
    endtask

    task automatic test_ramp_up();
        int exp_rate [3] = '{4, 7, 9};
        int exp_pred [3] = '{0, 0, 1};
        int exp_st   [3] = '{0, 0, 1};
        do_reset();
        wp_if.task_arrive = 1'b1;
        wp_if.task_done   = 1'b1;
        for (int w = 0; w < 3; w++) begin
            steps(15);
            checks++;
            if (wp_if.window_tick !== 1'b0) begin
                errors++;
                $display("FAIL ramp_up_pretick w%0d: got %0d required 0", w + 1, wp_if.window_tick);
            end
            step();
            checks++;
            if (wp_if.rate_avg !== 8'(exp_rate[w]) || wp_if.window_tick !== 1'b1 ||
                wp_if.predict !== 1'(exp_pred[w]) || wp_if.state_o !== 2'(exp_st[w]) ||
                wp_if.backlog !== 6'd0) begin
                errors++;
                $display("FAIL ramp_up w%0d: got r=%0d t=%0d p=%0d s=%0d b=%0d required r=%0d t=1 p=%0d s=%0d b=0",
                         w + 1, wp_if.rate_avg, wp_if.window_tick, wp_if.predict, wp_if.state_o,
                         wp_if.backlog, exp_rate[w], exp_pred[w], exp_st[w]);
            end
        end
    endtask

    task automatic test_ramp_down();
        int exp_rate [6] = '{7, 5, 4, 3, 2, 1};
        int exp_pred [6] = '{1, 1, 1, 1, 1, 0};
        int exp_st   [6] = '{1, 1, 1, 2, 2, 0};
        clear_inputs();
        for (int w = 0; w < 6; w++) begin
            steps(16);
            checks++;
            if (wp_if.rate_avg !== 8'(exp_rate[w]) || wp_if.predict !== 1'(exp_pred[w]) ||
                wp_if.state_o !== 2'(exp_st[w])) begin
                errors++;
                $display("FAIL ramp_down w%0d: got r=%0d p=%0d s=%0d required r=%0d p=%0d s=%0d",
                         w + 1, wp_if.rate_avg, wp_if.predict, wp_if.state_o,
                         exp_rate[w], exp_pred[w], exp_st[w]);
            end
        end
    endtask

    task automatic test_backlog_override();
        do_reset();
        wp_if.task_arrive = 1'b1;
        steps(16);
        checks++;
        if (wp_if.backlog !== 6'd16 || wp_if.predict !== 1'b0 || wp_if.state_o !== 2'd0 ||
            wp_if.rate_avg !== 8'd4) begin
            errors++;
            $display("FAIL override_fill: got b=%0d p=%0d s=%0d r=%0d required b=16 p=0 s=0 r=4",
                     wp_if.backlog, wp_if.predict, wp_if.state_o, wp_if.rate_avg);
        end
        wp_if.task_arrive = 1'b0;
        step();
        checks++;
        if (wp_if.predict !== 1'b1 || wp_if.state_o !== 2'd1 || wp_if.window_tick !== 1'b0) begin
            errors++;
            $display("FAIL override_on: got p=%0d s=%0d t=%0d required p=1 s=1 t=0",
                     wp_if.predict, wp_if.state_o, wp_if.window_tick);
        end
        wp_if.task_done = 1'b1;
        steps(15);
        checks++;
        if (wp_if.backlog !== 6'd1 || wp_if.predict !== 1'b1 || wp_if.state_o !== 2'd2 ||
            wp_if.rate_avg !== 8'd3) begin
            errors++;
            $display("FAIL override_hold: got b=%0d p=%0d s=%0d r=%0d required b=1 p=1 s=2 r=3",
                     wp_if.backlog, wp_if.predict, wp_if.state_o, wp_if.rate_avg);
        end
        step();
        wp_if.task_done = 1'b0;
        steps(15);
        checks++;
        if (wp_if.backlog !== 6'd0 || wp_if.predict !== 1'b1 || wp_if.state_o !== 2'd2 ||
            wp_if.rate_avg !== 8'd2) begin
            errors++;
            $display("FAIL override_hold2: got b=%0d p=%0d s=%0d r=%0d required b=0 p=1 s=2 r=2",
                     wp_if.backlog, wp_if.predict, wp_if.state_o, wp_if.rate_avg);
        end
        steps(16);
        checks++;
        if (wp_if.predict !== 1'b0 || wp_if.state_o !== 2'd0 || wp_if.rate_avg !== 8'd1) begin
            errors++;
            $display("FAIL override_off: got p=%0d s=%0d r=%0d required p=0 s=0 r=1",
                     wp_if.predict, wp_if.state_o, wp_if.rate_avg);
        end
    endtask

    task automatic test_backlog_edges();
        do_reset();
        wp_if.task_done = 1'b1;
        step();
        checks++;
        if (wp_if.backlog !== 6'd0) begin
            errors++;
            $display("FAIL backlog_underflow: got %0d required 0", wp_if.backlog);
        end
        wp_if.task_done   = 1'b0;
        wp_if.task_arrive = 1'b1;
        steps(5);
        checks++;
        if (wp_if.backlog !== 6'd5) begin
            errors++;
            $display("FAIL backlog_count5: got %0d required 5", wp_if.backlog);
        end
        wp_if.task_done = 1'b1;
        step();
        checks++;
        if (wp_if.backlog !== 6'd5) begin
            errors++;
            $display("FAIL backlog_both: got %0d required 5", wp_if.backlog);
        end
        wp_if.task_done = 1'b0;
        steps(57);
        checks++;
        if (wp_if.backlog !== 6'd62) begin
            errors++;
            $display("FAIL backlog_62: got %0d required 62", wp_if.backlog);
        end
        step();
        checks++;
        if (wp_if.backlog !== 6'd63) begin
            errors++;
            $display("FAIL backlog_63: got %0d required 63", wp_if.backlog);
        end
        steps(12);
        checks++;
        if (wp_if.backlog !== 6'd63) begin
            errors++;
            $display("FAIL backlog_saturate: got %0d required 63", wp_if.backlog);
        end
        wp_if.task_arrive = 1'b0;
        wp_if.task_done   = 1'b1;
        step();
        wp_if.task_done = 1'b0;
        checks++;
        if (wp_if.backlog !== 6'd62) begin
            errors++;
            $display("FAIL backlog_dec_from_sat: got %0d required 62", wp_if.backlog);
        end
    endtask

    task automatic test_force_async_reset();
        do_reset();
        steps(3);
        checks++;
        if (wp_if.predict !== 1'b0 || wp_if.state_o !== 2'd0) begin
            errors++;
            $display("FAIL force_pre: got p=%0d s=%0d required 0 0", wp_if.predict, wp_if.state_o);
        end
        wp_if.force_on = 1'b1;
        step();
        checks++;
        if (wp_if.predict !== 1'b1 || wp_if.state_o !== 2'd1) begin
            errors++;
            $display("FAIL force_on: got p=%0d s=%0d required 1 1", wp_if.predict, wp_if.state_o);
        end
        wp_if.force_on = 1'b0;
        step();
        checks++;
        if (wp_if.predict !== 1'b1 || wp_if.state_o !== 2'd1) begin
            errors++;
            $display("FAIL force_stay_on: got p=%0d s=%0d required 1 1", wp_if.predict, wp_if.state_o);
        end
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if (wp_if.predict !== 1'b0 || wp_if.state_o !== 2'd0 || wp_if.backlog !== 6'd0 ||
            wp_if.rate_avg !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: got p=%0d s=%0d b=%0d r=%0d required all 0",
                     wp_if.predict, wp_if.state_o, wp_if.backlog, wp_if.rate_avg);
        end
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        clear_inputs();
        test_reset();
        test_ramp_up();
        test_ramp_down();
        test_backlog_override();
        test_backlog_edges();
        test_force_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Bound on total run time
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule : tb_workload_predictor
`default_nettype wire
